// File: rtl/alu3_if.sv
// alu3_if: operand/opcode strobe and registered result bus for the alu3
// signed arithmetic unit. The master drives en/S/A/B; the slave (alu3)
// returns R and its flags together with the vld pulse.
interface alu3_if;
    logic       en;
    logic [1:0] S;
    logic [2:0] A;
    logic [2:0] B;
    logic [4:0] R;
    logic       ZF;
    logic       SF;
    logic       DZF;
    logic       vld;

    modport master (
        output en, S, A, B,
        input  R, ZF, SF, DZF, vld
    );

    modport slave (
        input  en, S, A, B,
        output R, ZF, SF, DZF, vld
    );
endinterface

// File: rtl/alu3.sv
// alu3: 3-bit signed add/divide/multiply/subtract unit with a registered
// 5-bit signed result, zero/sign/divide-by-zero flags and a vld pulse.
// Latency is one cycle from an en strobe.
//
// Build option: define ALU_SAT_EN to saturate results outside -16..15
// (only -4 * -4 = +16 can reach this); left undefined, results wrap to the
// low 5 bits.
module alu3 (
    input  logic  clk,
    input  logic  rst_n,
    alu3_if.slave bus
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_DIV = 2'b01,
        OP_MUL = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    op_e op;

    // 6-bit working width: wide enough for every raw result (-12..16)
    // so overflow can be detected before narrowing to 5 bits.
    logic signed [5:0] a_w;
    logic signed [5:0] b_w;
    logic signed [5:0] sum_w;
    logic signed [5:0] diff_w;
    logic signed [5:0] prod_w;
    logic signed [5:0] quot_w;
    logic signed [5:0] raw_w;

    // Divider working signals (operates on magnitudes).
    logic [2:0] mag_a;
    logic [2:0] mag_b;
    logic [2:0] div_rem;
    logic [2:0] div_quo;
    logic [2:0] div_sh;
    logic       quot_neg;
    logic       div_zero;

    // Narrowed result and flags for the current operands.
    logic [4:0] res;
    logic       res_zf;
    logic       res_sf;

    // Output registers.
    logic [4:0] r_d,   r_q;
    logic       zf_d,  zf_q;
    logic       sf_d,  sf_q;
    logic       dzf_d, dzf_q;
    logic       vld_d, vld_q;

    assign op = op_e'(bus.S);

    // Sign-extend operands and form the add/sub/mul candidates.
    always_comb begin
        a_w    = {{3{bus.A[2]}}, bus.A};
        b_w    = {{3{bus.B[2]}}, bus.B};
        sum_w  = a_w + b_w;
        diff_w = a_w - b_w;
        prod_w = a_w * b_w;
    end

    // Truncating division: restoring divide of the magnitudes, then apply
    // the sign, which gives round-toward-zero for free. mag of -4 is 3'b100.
    always_comb begin
        mag_a    = bus.A[2] ? (~bus.A + 3'd1) : bus.A;
        mag_b    = bus.B[2] ? (~bus.B + 3'd1) : bus.B;
        quot_neg = bus.A[2] ^ bus.B[2];
        div_zero = (bus.B == 3'd0);
        div_rem  = '0;
        div_quo  = '0;
        div_sh   = mag_a;
        for (int unsigned i = 0; i < 3; i++) begin
            // Partial remainder is always < mag_b <= 4, so its top bit is
            // clear and the shift cannot lose information.
            div_rem = {div_rem[1:0], div_sh[2]};
            div_sh  = {div_sh[1:0], 1'b0};
            if (div_rem >= mag_b) begin
                div_rem = div_rem - mag_b;
                div_quo = {div_quo[1:0], 1'b1};
            end else begin
                div_quo = {div_quo[1:0], 1'b0};
            end
        end
        quot_w = quot_neg ? -$signed({3'b000, div_quo}) : $signed({3'b000, div_quo});
    end

    // Select the raw result by opcode, then narrow it to 5 bits.
    always_comb begin
        raw_w = '0;
        unique case (op)
            OP_ADD: raw_w = sum_w;
            OP_DIV: raw_w = div_zero ? 6'sd0 : quot_w;
            OP_MUL: raw_w = prod_w;
            OP_SUB: raw_w = diff_w;
            default: raw_w = '0;
        endcase
`ifdef ALU_SAT_EN
        if (raw_w > 6'sd15) begin
            res = 5'b01111;
        end else if (raw_w < -6'sd16) begin
            res = 5'b10000;
        end else begin
            res = raw_w[4:0];
        end
`else
        res = raw_w[4:0];
`endif
    end

    // Flags on the final result; a divide by zero forces them clear.
    always_comb begin
        res_zf = 1'b0;
        res_sf = 1'b0;
        if (!(op == OP_DIV && div_zero)) begin
            res_zf = (res == 5'd0);
            res_sf = res[4];
        end
    end

    // Next-state: capture on en, otherwise hold; vld follows en.
    always_comb begin
        r_d   = r_q;
        zf_d  = zf_q;
        sf_d  = sf_q;
        dzf_d = dzf_q;
        vld_d = bus.en;
        if (bus.en) begin
            r_d   = res;
            zf_d  = res_zf;
            sf_d  = res_sf;
            dzf_d = (op == OP_DIV) && div_zero;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            zf_q  <= 1'b0;
            sf_q  <= 1'b0;
            dzf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            r_q   <= r_d;
            zf_q  <= zf_d;
            sf_q  <= sf_d;
            dzf_q <= dzf_d;
            vld_q <= vld_d;
        end
    end

    assign bus.R   = r_q;
    assign bus.ZF  = zf_q;
    assign bus.SF  = sf_q;
    assign bus.DZF = dzf_q;
    assign bus.vld = vld_q;

endmodule

// File: tb/tb_alu3.sv
// tb_alu3: directed and random checks of alu3 against an integer model.
module tb_alu3;

    logic clk;
    logic rst_n;

    alu3_if bus ();

    alu3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected registered outputs.
    logic [4:0] m_r;
    logic       m_zf, m_sf, m_dzf, m_vld;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".R"},   bus.R,          m_r);
        chk({tag, ".ZF"},  {4'b0, bus.ZF},  {4'b0, m_zf});
        chk({tag, ".SF"},  {4'b0, bus.SF},  {4'b0, m_sf});
        chk({tag, ".DZF"}, {4'b0, bus.DZF}, {4'b0, m_dzf});
        chk({tag, ".vld"}, {4'b0, bus.vld}, {4'b0, m_vld});
    endtask

    task automatic model_reset();
        m_r = '0; m_zf = 0; m_sf = 0; m_dzf = 0; m_vld = 0;
    endtask

    // Arithmetic straight from the operation rules, on plain integers.
    task automatic model_op(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
        int ia, ib, r;
        logic dz;
        ia = $signed(a);
        ib = $signed(b);
        dz = 0;
        r  = 0;
        case (s)
            2'b00: r = ia + ib;
            2'b01: if (ib == 0) dz = 1; else r = ia / ib;
            2'b10: r = ia * ib;
            default: r = ia - ib;
        endcase
`ifdef ALU_SAT_EN
        if (r > 15)  r = 15;
        if (r < -16) r = -16;
`endif
        m_r   = 5'(r);
        m_dzf = dz;
        m_zf  = dz ? 1'b0 : (m_r == 5'd0);
        m_sf  = dz ? 1'b0 : m_r[4];
        m_vld = 1'b1;
    endtask

    task automatic step(input logic e, input logic [1:0] s, input logic [2:0] a,
                        input logic [2:0] b, input string tag);
        @(negedge clk);
        bus.en = e; bus.S = s; bus.A = a; bus.B = b;
        @(posedge clk);
        if (e) model_op(s, a, b);
        else   m_vld = 1'b0;
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst_n  = 1'b1;
        bus.en = 1'b1;
        bus.S  = 2'(3);
        bus.A  = 3'(5);
        bus.B  = 3'(6);
        model_reset();

        // Reset with en high: outputs clear without waiting for a clock.
        #2 rst_n = 1'b0;
        #1 chk_all("rst_async");
        @(posedge clk); #1 chk_all("rst_held_clk1");
        @(posedge clk); #1 chk_all("rst_held_clk2");
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
        step(0, 2'b00, 3'd3, 3'd1, "post_rst_idle");

        // Directed cases (A/B as 3-bit two's complement).
        step(1, 2'b00, 3'd3, 3'b110, "add_3_m2");
        step(1, 2'b11, 3'd2, 3'b101, "sub_2_m3");
        step(1, 2'b11, 3'd1, 3'd1,   "sub_1_1");
        step(1, 2'b01, 3'b101, 3'd2, "div_m3_2");
        step(1, 2'b01, 3'd3, 3'b110, "div_3_m2");
        step(1, 2'b01, 3'd3, 3'd0,   "div_by_zero");
        step(1, 2'b01, 3'b100, 3'b111, "div_m4_m1");
        step(1, 2'b10, 3'b111, 3'b110, "mul_m1_m2");
        step(1, 2'b10, 3'd3, 3'b100,   "mul_3_m4");
        step(1, 2'b10, 3'b100, 3'b100, "mul_m4_m4");
        step(1, 2'b00, 3'b100, 3'b100, "add_m4_m4");
        step(1, 2'b11, 3'd3, 3'b100,   "sub_3_m4");

        // Hold: inputs change with en low.
        step(0, 2'b10, 3'd2, 3'd3,   "hold1");
        step(0, 2'b01, 3'd1, 3'd0,   "hold2");
        step(1, 2'b01, 3'd1, 3'd0,   "dz_then");
        step(0, 2'b00, 3'd1, 3'd1,   "hold_dz");

        // Streaming: en stays high over three operand sets.
        step(1, 2'b00, 3'd1, 3'd2,   "stream0");
        step(1, 2'b10, 3'd3, 3'd3,   "stream1");
        step(1, 2'b11, 3'b100, 3'd3, "stream2");

        // Random operations with random en.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(1, 0) | (i < 150 ? 1 : 0)),
                 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
                 3'($urandom_range(7, 0)), "rand");
        end

        // Reset mid-stream, between two en cycles.
        step(1, 2'b10, 3'd2, 3'b111, "pre_mid_rst");
        @(negedge clk);
        bus.en = 1'b1; bus.S = 2'b00; bus.A = 3'd3; bus.B = 3'd3;
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all("mid_rst_async");
        @(posedge clk); #1 chk_all("mid_rst_held");
        @(negedge clk);
        bus.en = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1 chk_all("mid_rst_released_idle");
        step(1, 2'b01, 3'b100, 3'd2, "after_mid_rst");
        step(0, 2'b00, 3'd0, 3'd0,   "after_mid_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
